i2f: RTL and testbench

I2F -- requirements
Module: i2f

---
 rtl/i2f.sv | 82 ++++++++
 tb/tb_i2f.sv | 112 +++++++++++
 2 files changed

// File: rtl/i2f.sv
// rtl/i2f.sv - signed 32-bit integer to IEEE-754 single conversion, truncating, 1-cycle latency
module i2f (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d,
    input  logic        in_valid,
    output logic [31:0] a,
    output logic        p_lost,
    output logic        out_valid
);

    logic        sign;
    logic [31:0] m;
    logic [31:0] s16;
    logic [31:0] s8;
    logic [31:0] s4;
    logic [31:0] s2;
    logic [31:0] f0;
    logic [4:0]  sa;
    logic [7:0]  exp_field;
    logic [31:0] result;
    logic        lost;

    // Leading-zero count and normalization as a 16/8/4/2/1 binary shifter
    always_comb begin
        sign = d[31];
        m    = sign ? (~d + 32'd1) : d;
        sa   = 5'd0;

        s16 = m;
        if (m[31:16] == 16'd0) begin
            s16   = m << 16;
            sa[4] = 1'b1;
        end
        s8 = s16;
        if (s16[31:24] == 8'd0) begin
            s8    = s16 << 8;
            sa[3] = 1'b1;
        end
        s4 = s8;
        if (s8[31:28] == 4'd0) begin
            s4    = s8 << 4;
            sa[2] = 1'b1;
        end
        s2 = s4;
        if (s4[31:30] == 2'd0) begin
            s2    = s4 << 2;
            sa[1] = 1'b1;
        end
        f0 = s2;
        if (s2[31] == 1'b0) begin
            f0    = s2 << 1;
            sa[0] = 1'b1;
        end

        exp_field = 8'd158 - {3'b000, sa};

        // Zero has no leading one; force +0 rather than a tiny normal
        if (m == 32'd0) begin
            result = 32'd0;
            lost   = 1'b0;
        end else begin
            result = {sign, exp_field, f0[30:8]};
            lost   = |f0[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= 32'd0;
            p_lost    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                a      <= result;
                p_lost <= lost;
            end
        end
    end

endmodule

// File: tb/tb_i2f.sv
// tb/tb_i2f.sv - directed self-checking bench for i2f
module tb_i2f;

    logic        clk;
    logic        rst;
    logic [31:0] d;
    logic        in_valid;
    logic [31:0] a;
    logic        p_lost;
    logic        out_valid;

    int n_checks;
    int n_fail;

    i2f dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .in_valid  (in_valid),
        .a         (a),
        .p_lost    (p_lost),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic iv, input logic [31:0] dv);
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        d        = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_result(input string tag, input logic [31:0] ea, input logic ep);
        check({tag, " a"}, a, ea);
        check({tag, " p_lost"}, {31'd0, p_lost}, {31'd0, ep});
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        d        = 32'd0;

        // Reset with a conversion presented: it must be discarded
        step(1'b1, 1'b1, 32'h0000_0001);
        step(1'b1, 1'b1, 32'h1FFF_FFFF);
        check("reset a", a, 32'd0);
        check("reset p_lost", {31'd0, p_lost}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);

        // Idle after reset release
        step(1'b0, 1'b0, 32'h1234_5678);
        check("idle out_valid", {31'd0, out_valid}, 32'd0);
        check("idle a", a, 32'd0);

        // Back-to-back reference vectors
        step(1'b0, 1'b1, 32'h0000_0001); expect_result("d=00000001", 32'h3F80_0000, 1'b0);
        step(1'b0, 1'b1, 32'h1FFF_FFFF); expect_result("d=1FFFFFFF", 32'h4DFF_FFFF, 1'b1);
        step(1'b0, 1'b1, 32'h7FFF_FF80); expect_result("d=7FFFFF80", 32'h4EFF_FFFF, 1'b0);
        step(1'b0, 1'b1, 32'h7FFF_FFC0); expect_result("d=7FFFFFC0", 32'h4EFF_FFFF, 1'b1);
        step(1'b0, 1'b1, 32'h8000_0000); expect_result("d=80000000", 32'hCF00_0000, 1'b0);
        step(1'b0, 1'b1, 32'h8000_0040); expect_result("d=80000040", 32'hCEFF_FFFF, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFF); expect_result("d=FFFFFFFF", 32'hBF80_0000, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0000); expect_result("d=00000000", 32'h0000_0000, 1'b0);

        // Extra patterns
        step(1'b0, 1'b1, 32'h0000_0100); expect_result("d=00000100", 32'h4380_0000, 1'b0);
        step(1'b0, 1'b1, 32'hFFFF_FFFE); expect_result("d=FFFFFFFE", 32'hC000_0000, 1'b0);
        step(1'b0, 1'b1, 32'h7FFF_FFFF); expect_result("d=7FFFFFFF", 32'h4EFF_FFFF, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0003); expect_result("d=00000003", 32'h4040_0000, 1'b0);

        // Gap: outputs hold last result with out_valid low
        step(1'b0, 1'b1, 32'h7FFF_FFC0); expect_result("pre-gap", 32'h4EFF_FFFF, 1'b1);
        step(1'b0, 1'b0, 32'h0000_0001);
        check("gap out_valid", {31'd0, out_valid}, 32'd0);
        check("gap a hold", a, 32'h4EFF_FFFF);
        check("gap p_lost hold", {31'd0, p_lost}, 32'd1);
        step(1'b0, 1'b0, 32'h8000_0000);
        check("gap2 a hold", a, 32'h4EFF_FFFF);
        check("gap2 out_valid", {31'd0, out_valid}, 32'd0);

        // Mid-stream reset drops the in-flight conversion
        step(1'b0, 1'b1, 32'h1FFF_FFFF); expect_result("pre-rst", 32'h4DFF_FFFF, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("midrst a", a, 32'd0);
        check("midrst p_lost", {31'd0, p_lost}, 32'd0);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 32'h8000_0040); expect_result("post-rst", 32'hCEFF_FFFF, 1'b1);
        step(1'b0, 1'b0, 32'h0000_0000);
        check("tail out_valid", {31'd0, out_valid}, 32'd0);
        check("tail a hold", a, 32'hCEFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
